uart_cfg: RTL



---
 rtl/uart_cfg.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// Configurable UART: DATA_BITS/PARITY/STOP_BITS framing, TX and RX FIFOs,
// and sticky parity/framing/overrun flags cleared by error_clear.
module uart_cfg #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       error_clear,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       tx_busy,
  input  logic       serial_in,
  output logic       serial_out
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic RX_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t tx_state;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic tx_empty, tx_full, tx_push;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic tx_par;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_push = data_in_valid && !tx_full;
  assign data_in_ready = !tx_full;
  assign tx_busy = (tx_state != S_IDLE) || !tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= data_in & DATA_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tx_wr <= '0;
    else if (tx_push) tx_wr <= tx_wr + 1'b1;
  end

  // serial_out is driven from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_rd <= '0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
      tx_par <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_mem[tx_rd[AW-1:0]];
            tx_par <= ^tx_mem[tx_rd[AW-1:0]] ^ PAR_ODD;
            tx_rd <= tx_rd + 1'b1;
            tx_cnt <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_state <= S_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_bit == DATA_LAST) tx_state <= HAS_PARITY ? S_PARITY : S_STOP;
            else tx_bit <= tx_bit + 1'b1;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        S_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_state <= S_STOP;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        S_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt <= '0;
            tx_state <= S_IDLE;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
      case (tx_state)
        S_START:  serial_out <= 1'b0;
        S_DATA:   serial_out <= tx_shift[0];
        S_PARITY: serial_out <= tx_par;
        default:  serial_out <= 1'b1;
      endcase
    end
  end

  state_t rx_state;
  logic sync1, rx_in;
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd;
  logic rx_empty, rx_full, rx_pop, rx_push;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit;
  logic rx_stop, rx_stop_bad, rx_par_bit;
  logic [7:0] rx_shift;
  logic rx_last, frame_bad, par_bad, rx_good;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_in <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_in <= sync1;
    end
  end

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign data_out_valid = !rx_empty;
  assign data_out = rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];
  assign rx_pop = data_out_valid && data_out_ready;

  // Frame verdict is taken on the cycle of the final stop-bit sample
  assign rx_last = (rx_state == S_STOP) && (rx_cnt == BIT_LAST) && (rx_stop == RX_STOP_LAST);
  assign frame_bad = rx_stop_bad || !rx_in;
  assign par_bad = HAS_PARITY && (rx_par_bit != (^rx_shift ^ PAR_ODD));
  assign rx_good = rx_last && !frame_bad && !par_bad;
  assign rx_push = rx_good && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_stop <= 1'b0;
      rx_stop_bad <= 1'b0;
      rx_par_bit <= 1'b0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (!rx_in) begin
            rx_cnt <= '0;
            rx_shift <= '0;
            rx_stop_bad <= 1'b0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_in ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_shift[rx_bit] <= rx_in;
            if (rx_bit == DATA_LAST) begin
              rx_stop <= 1'b0;
              rx_state <= HAS_PARITY ? S_PARITY : S_STOP;
            end else rx_bit <= rx_bit + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_par_bit <= rx_in;
            rx_stop <= 1'b0;
            rx_state <= S_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (!rx_in) rx_stop_bad <= 1'b1;
            if (rx_stop == RX_STOP_LAST) rx_state <= S_IDLE;
            else rx_stop <= rx_stop + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift & DATA_MASK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
    end
  end

  // A new event in the same cycle as error_clear keeps the flag set
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_error <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      parity_error <= (rx_last && par_bad) || (parity_error && !error_clear);
      framing_error <= (rx_last && frame_bad) || (framing_error && !error_clear);
      overrun_error <= (rx_good && rx_full && !rx_pop) || (overrun_error && !error_clear);
    end
  end

endmodule
